// File: rtl/text_char_buffer_pkg.sv
// ============================================================================
// text_pkg : shared codes and FSM encoding for the text character buffer
// Rev 1.0
// ============================================================================
`default_nettype none

package text_pkg;

    localparam logic [7:0] CHAR_FF     = 8'h0C;
    localparam logic [7:0] CHAR_NL     = 8'h0A;
    localparam logic [7:0] CHAR_BS     = 8'h08;
    localparam logic [7:0] CHAR_SPACE  = 8'h20;
    localparam logic [7:0] CHAR_CURSOR = 8'h5F;

    typedef enum logic {TB_CLEAR, TB_IDLE} tb_state_t;

endpackage

`default_nettype wire

// File: rtl/text_char_buffer_char_ram.sv
// ============================================================================
// char_ram : simple dual-port character RAM, sync write, sync old-data read
// Rev 1.0
// ============================================================================
`default_nettype none

module char_ram #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    // Read samples the array before this edge's write lands: old data on collision.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/text_char_buffer.sv
// ============================================================================
// text_char_buffer : host-written text cell buffer scanned by VGA pixel counters
// Optional cursor blink overlay enabled by macro CURSOR_BLINK_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module text_char_buffer
    import text_pkg::*;
#(
    parameter int COLS      = 16,
    parameter int ROWS      = 8,
    parameter int CELL_W    = 32,
    parameter int CELL_H    = 32,
    parameter int ORIGIN_X  = 64,
    parameter int ORIGIN_Y  = 96,
    parameter int BLINK_CYC = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] counterX,
    input  logic [12:0] counterY,
    input  logic        wr_valid,
    input  logic [7:0]  wr_char,
    output logic        wr_ready,
    output logic [7:0]  char,
    output logic [9:0]  posX,
    output logic [9:0]  posY,
    output logic        in_text
);

    localparam int DEPTH  = COLS * ROWS;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int LOG_CW = $clog2(CELL_W);
    localparam int LOG_CH = $clog2(CELL_H);

    // ------------------------------------------------------------------
    // Host side: clear sweep and cursor-driven writes
    // ------------------------------------------------------------------
    tb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d;
    logic [ROW_W-1:0]  w_next_row;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [7:0]        w_wdata;

    assign wr_ready   = (state_q == TB_IDLE);
    assign w_next_row = cursor_q[ADDR_W-1:COL_W] + ROW_W'(1);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        cursor_d   = cursor_q;
        w_we       = 1'b0;
        w_waddr    = cursor_q;
        w_wdata    = wr_char;
        case (state_q)
            TB_CLEAR: begin
                w_we       = 1'b1;
                w_waddr    = clr_addr_q;
                w_wdata    = CHAR_SPACE;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                    cursor_d = '0;
                    state_d  = TB_IDLE;
                end
            end
            TB_IDLE: begin
                if (wr_valid) begin
                    case (wr_char)
                        CHAR_FF: begin
                            state_d    = TB_CLEAR;
                            clr_addr_d = '0;
                        end
                        CHAR_NL: cursor_d = {w_next_row, {COL_W{1'b0}}};
                        CHAR_BS: begin
                            if (cursor_q != '0) begin
                                cursor_d = cursor_q - ADDR_W'(1);
                            end
                        end
                        default: begin
                            w_we     = 1'b1;
                            cursor_d = cursor_q + ADDR_W'(1);
                        end
                    endcase
                end
            end
            default: state_d = TB_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= TB_CLEAR;
            clr_addr_q <= '0;
            cursor_q   <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            cursor_q   <= cursor_d;
        end
    end

    // ------------------------------------------------------------------
    // Scan side: pixel -> cell address, origin and inside flag
    // ------------------------------------------------------------------
    logic [12:0]       w_dx, w_dy;
    logic              w_inside;
    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [9:0]        w_px, w_py;
    logic [7:0]        w_rd_data;
    logic              in_text_q;
    logic [9:0]        posx_q, posy_q;

    assign w_dx      = counterX - 13'(ORIGIN_X);
    assign w_dy      = counterY - 13'(ORIGIN_Y);
    assign w_inside  = (counterX >= 13'(ORIGIN_X)) && (w_dx < 13'(COLS * CELL_W)) &&
                       (counterY >= 13'(ORIGIN_Y)) && (w_dy < 13'(ROWS * CELL_H));
    assign w_col     = w_dx[LOG_CW +: COL_W];
    assign w_row     = w_dy[LOG_CH +: ROW_W];
    assign w_rd_addr = {w_row, w_col};
    assign w_px      = 10'(ORIGIN_X) + (10'(w_col) << LOG_CW);
    assign w_py      = 10'(ORIGIN_Y) + (10'(w_row) << LOG_CH);

    // Reset is folded into the write enable so a transfer in flight at reset is dropped.
    char_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_char_ram (
        .clk       (clk),
        .wr_en_i   (w_we & rst_n),
        .wr_addr_i (w_waddr),
        .wr_data_i (w_wdata),
        .rd_addr_i (w_rd_addr),
        .rd_data_o (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_text_q <= 1'b0;
            posx_q    <= 10'(ORIGIN_X);
            posy_q    <= 10'(ORIGIN_Y);
        end else begin
            in_text_q <= w_inside;
            if (w_inside) begin
                posx_q <= w_px;
                posy_q <= w_py;
            end
        end
    end

    assign in_text = in_text_q;
    assign posX    = posx_q;
    assign posY    = posy_q;

`ifdef CURSOR_BLINK_EN
    localparam int BLINK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_on_q;
    logic               cur_hit_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b0;
            cur_hit_q   <= 1'b0;
        end else begin
            if (blink_cnt_q == BLINK_W'(BLINK_CYC - 1)) begin
                blink_cnt_q <= '0;
                blink_on_q  <= ~blink_on_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
            end
            cur_hit_q <= (w_rd_addr == cursor_q) && blink_on_q;
        end
    end

    assign char = !in_text_q ? 8'h00 : (cur_hit_q ? CHAR_CURSOR : w_rd_data);
`else
    logic w_unused_blink;
    assign w_unused_blink = (BLINK_CYC != 0);
    assign char = in_text_q ? w_rd_data : 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_text_char_buffer.sv
// ============================================================================
// tb_text_char_buffer : directed self-checking bench for text_char_buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_text_char_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] counterX = '0;
    logic [12:0] counterY = '0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_char = '0;
    logic        wr_ready;
    logic [7:0]  char;
    logic [9:0]  posX, posY;
    logic        in_text;

    int n_cmp = 0;
    int n_err = 0;

    text_char_buffer #(
        .COLS(16), .ROWS(8), .CELL_W(32), .CELL_H(32),
        .ORIGIN_X(64), .ORIGIN_Y(96), .BLINK_CYC(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .counterX(counterX), .counterY(counterY),
        .wr_valid(wr_valid), .wr_char(wr_char), .wr_ready(wr_ready),
        .char(char), .posX(posX), .posY(posY), .in_text(in_text)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        int t;
        wr_valid = 1'b1;
        wr_char  = c;
        t = 0;
        while (!wr_ready && t < 500) begin
            tick();
            t++;
        end
        if (t >= 500) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout code %h never accepted", c);
        end
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic scan(input int x, input int y);
        counterX = 13'(x);
        counterY = 13'(y);
        tick();
    endtask

    // Counts cycles with wr_ready low, bounded.
    task automatic count_busy(output int t);
        t = 0;
        while (!wr_ready && t < 1000) begin
            tick();
            t++;
        end
    endtask

    task automatic test_reset();
        int t;
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++; if (char !== 8'h00) begin n_err++; $display("FAIL rst_char got %h exp 00", char); end
        n_cmp++; if (posX !== 10'd64) begin n_err++; $display("FAIL rst_posX got %0d exp 64", posX); end
        n_cmp++; if (posY !== 10'd96) begin n_err++; $display("FAIL rst_posY got %0d exp 96", posY); end
        n_cmp++; if (in_text !== 1'b0) begin n_err++; $display("FAIL rst_in_text got %b exp 0", in_text); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL rst_wr_ready got %b exp 0", wr_ready); end
        rst_n = 1'b1;
        count_busy(t);
        n_cmp++; if (t != 128) begin n_err++; $display("FAIL rst_clear_len got %0d exp 128", t); end
        scan(64, 96);
        n_cmp++; if (char !== 8'h20) begin n_err++; $display("FAIL rst_cell0 got %h exp 20", char); end
        scan(544, 320);
        n_cmp++; if (char !== 8'h20) begin n_err++; $display("FAIL rst_cell127 got %h exp 20", char); end
        scan(128, 192);
        n_cmp++; if (char !== 8'h20) begin n_err++; $display("FAIL rst_cell50 got %h exp 20", char); end
    endtask

    task automatic test_write_ab();
        send(8'h41);
        send(8'h42);
        scan(64, 96);
        n_cmp++; if (char !== 8'h41) begin n_err++; $display("FAIL ab_char0 got %h exp 41", char); end
        n_cmp++; if (posX !== 10'd64) begin n_err++; $display("FAIL ab_posX0 got %0d exp 64", posX); end
        n_cmp++; if (posY !== 10'd96) begin n_err++; $display("FAIL ab_posY0 got %0d exp 96", posY); end
        n_cmp++; if (in_text !== 1'b1) begin n_err++; $display("FAIL ab_in_text got %b exp 1", in_text); end
        scan(96, 96);
        n_cmp++; if (char !== 8'h42) begin n_err++; $display("FAIL ab_char1 got %h exp 42", char); end
        n_cmp++; if (posX !== 10'd96) begin n_err++; $display("FAIL ab_posX1 got %0d exp 96", posX); end
        // Interior pixel of the same cell keeps the cell origin.
        scan(120, 127);
        n_cmp++; if (posX !== 10'd96 || char !== 8'h42) begin n_err++; $display("FAIL ab_interior got %0d/%h exp 96/42", posX, char); end
    endtask

    task automatic test_newline();
        for (int i = 0; i < 16; i++) send(8'h61 + 8'(i));
        send(8'h0A);
        send(8'h43);
        scan(64, 160);
        n_cmp++; if (char !== 8'h43) begin n_err++; $display("FAIL nl_char got %h exp 43", char); end
        n_cmp++; if (posY !== 10'd160) begin n_err++; $display("FAIL nl_posY got %0d exp 160", posY); end
        scan(96, 128);
        n_cmp++; if (char !== 8'h70) begin n_err++; $display("FAIL nl_cell17 got %h exp 70", char); end
        scan(128, 128);
        n_cmp++; if (char !== 8'h20) begin n_err++; $display("FAIL nl_cell18 got %h exp 20", char); end
    endtask

    task automatic test_backspace();
        send(8'h08);
        send(8'h08);
        send(8'h58);
        scan(544, 128);
        n_cmp++; if (char !== 8'h58) begin n_err++; $display("FAIL bs_cell31 got %h exp 58", char); end
        n_cmp++; if (posX !== 10'd544) begin n_err++; $display("FAIL bs_posX got %0d exp 544", posX); end
        scan(64, 160);
        n_cmp++; if (char !== 8'h43) begin n_err++; $display("FAIL bs_cell32 got %h exp 43", char); end
    endtask

    task automatic test_clear();
        int t;
        send(8'h0C);
        count_busy(t);
        n_cmp++; if (t != 128) begin n_err++; $display("FAIL ff_clear_len got %0d exp 128", t); end
        scan(544, 128);
        n_cmp++; if (char !== 8'h20) begin n_err++; $display("FAIL ff_cell31 got %h exp 20", char); end
        scan(64, 160);
        n_cmp++; if (char !== 8'h20) begin n_err++; $display("FAIL ff_cell32 got %h exp 20", char); end
        // Backspace at cursor 0 saturates, so 'Z' lands in cell 0.
        send(8'h08);
        send(8'h5A);
        scan(64, 96);
        n_cmp++; if (char !== 8'h5A) begin n_err++; $display("FAIL bs_sat_cell0 got %h exp 5a", char); end
        scan(96, 96);
        n_cmp++; if (char !== 8'h20) begin n_err++; $display("FAIL bs_sat_cell1 got %h exp 20", char); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 7; i++) send(8'h0A);
        for (int i = 0; i < 16; i++) send(8'h61 + 8'(i));
        send(8'h51);
        scan(544, 320);
        n_cmp++; if (char !== 8'h70) begin n_err++; $display("FAIL wrap_cell127 got %h exp 70", char); end
        scan(64, 96);
        n_cmp++; if (char !== 8'h51) begin n_err++; $display("FAIL wrap_cell0 got %h exp 51", char); end
        for (int i = 0; i < 8; i++) send(8'h0A);
        send(8'h52);
        scan(64, 96);
        n_cmp++; if (char !== 8'h52) begin n_err++; $display("FAIL rowwrap_cell0 got %h exp 52", char); end
        scan(64, 128);
        n_cmp++; if (char !== 8'h20) begin n_err++; $display("FAIL rowwrap_cell16 got %h exp 20", char); end
    endtask

    task automatic test_outside();
        scan(575, 351);
        n_cmp++; if (in_text !== 1'b1 || char !== 8'h70) begin n_err++; $display("FAIL corner got %b/%h exp 1/70", in_text, char); end
        n_cmp++; if (posX !== 10'd544 || posY !== 10'd320) begin n_err++; $display("FAIL corner_pos got %0d,%0d exp 544,320", posX, posY); end
        scan(63, 96);
        n_cmp++; if (in_text !== 1'b0 || char !== 8'h00) begin n_err++; $display("FAIL left_edge got %b/%h exp 0/00", in_text, char); end
        n_cmp++; if (posX !== 10'd544 || posY !== 10'd320) begin n_err++; $display("FAIL hold_pos got %0d,%0d exp 544,320", posX, posY); end
        scan(576, 96);
        n_cmp++; if (in_text !== 1'b0 || char !== 8'h00) begin n_err++; $display("FAIL right_edge got %b/%h exp 0/00", in_text, char); end
        scan(64, 95);
        n_cmp++; if (in_text !== 1'b0 || char !== 8'h00) begin n_err++; $display("FAIL top_edge got %b/%h exp 0/00", in_text, char); end
        scan(64, 352);
        n_cmp++; if (in_text !== 1'b0 || char !== 8'h00) begin n_err++; $display("FAIL bottom_edge got %b/%h exp 0/00", in_text, char); end
    endtask

    task automatic test_collision();
        counterX = 13'd96;
        counterY = 13'd96;
        wr_valid = 1'b1;
        wr_char  = 8'h4B;
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL col_ready got %b exp 1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        n_cmp++; if (char !== 8'h20) begin n_err++; $display("FAIL col_old got %h exp 20", char); end
        tick();
        n_cmp++; if (char !== 8'h4B) begin n_err++; $display("FAIL col_new got %h exp 4b", char); end
    endtask

    task automatic test_reset_mid_clear();
        int t;
        send(8'h0C);
        repeat (20) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++; if (wr_ready !== 1'b0 || in_text !== 1'b0) begin n_err++; $display("FAIL midrst_state got %b/%b exp 0/0", wr_ready, in_text); end
        rst_n = 1'b1;
        count_busy(t);
        n_cmp++; if (t != 128) begin n_err++; $display("FAIL midrst_clear_len got %0d exp 128", t); end
        scan(96, 96);
        n_cmp++; if (char !== 8'h20) begin n_err++; $display("FAIL midrst_cell1 got %h exp 20", char); end
    endtask

`ifdef CURSOR_BLINK_EN
    task automatic test_blink();
        int on_cnt;
        on_cnt = 0;
        counterX = 13'd64;
        counterY = 13'd96;
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            if (char === 8'h5F) on_cnt++;
        end
        n_cmp++; if (on_cnt != 8) begin n_err++; $display("FAIL blink_on_cycles got %0d exp 8", on_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_ab();
        test_newline();
        test_backspace();
        test_clear();
        test_wrap();
        test_outside();
        test_collision();
        test_reset_mid_clear();
`ifdef CURSOR_BLINK_EN
        test_blink();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
